can_tx_arbiter: RTL

CAN_TX_ARBITER -- requirements
Module: can_tx_arbiter

---
 rtl/can_tx_arbiter_pkg.sv | 26 ++
 rtl/can_rr_pick.sv | 39 +++
 rtl/can_tx_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/can_tx_arbiter_pkg.sv
// Shared types for the CAN TX arbiter: FSM encoding, word and source-id widths.
// The pointer-wrap helper is shared by the top and any future requester logic.
package can_tx_arbiter_pkg;

    localparam int WORD_W = 32;
    localparam int SRC_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [SRC_W-1:0]  src_t;

    // Next round-robin pointer after requester v, wrapping at n.
    function automatic src_t wrap_inc(input src_t v, input int n);
        int nxt;
        nxt = int'(v) + 1;
        if (nxt >= n) begin
            return '0;
        end
        return src_t'(nxt);
    endfunction

endpackage

// File: rtl/can_rr_pick.sv
// Round-robin pick: lowest requester at or above ptr wins, else lowest overall.
// Pure combinational, zero latency; no flow control of its own.
module can_rr_pick
    import can_tx_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  src_t         ptr,
    output logic [N-1:0] gnt,
    output src_t         idx,
    output logic         any
);

    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (src_t'(i) >= ptr)) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                idx    = src_t'(i);
            end
        end
        // Nothing at or above the pointer: wrap around to the bottom.
        for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                idx    = src_t'(i);
            end
        end
        any = found;
    end

endmodule

// File: rtl/can_tx_arbiter.sv
// Merges N_REQ requester word streams and a periodic heartbeat onto the CAN TX stream.
// Latency 1 cycle req_valid->tx_valid; word held until tx_ready, requesters stalled meanwhile.
module can_tx_arbiter
    import can_tx_arbiter_pkg::*;
#(
    parameter int          N_REQ     = 4,
    parameter logic [31:0] HB_PERIOD = 32'd1000000,
    parameter logic [31:0] HB_DATA   = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hb_en,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [WORD_W*N_REQ-1:0] req_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [WORD_W-1:0]       tx_data,
    output logic [SRC_W-1:0]        cur_src,
    output logic                    hb_miss,
    output logic [15:0]             tx_count
);

    localparam src_t        HB_SRC    = src_t'(N_REQ);
    localparam logic [31:0] HB_RELOAD = HB_PERIOD - 32'd1;

    state_t        state_q;
    state_t        state_d;
    word_t         tx_data_q;
    src_t          cur_src_q;
    src_t          rr_ptr_q;
    logic [15:0]   tx_count_q;
    logic [31:0]   hb_cnt_q;
    logic          hb_pending_q;
    logic          hb_miss_q;

    logic [N_REQ-1:0] pick_gnt;
    src_t             pick_idx;
    logic             pick_any;
    word_t            pick_data;

    logic capture_hb;
    logic capture_req;
    logic handshake;
    logic hb_in_send;
    logic hb_done;
    logic hb_expire;

    can_rr_pick #(
        .N (N_REQ)
    ) u_pick (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_gnt[i]) begin
                pick_data = pick_data | req_data[i*WORD_W +: WORD_W];
            end
        end
    end

    assign handshake  = (state_q == SEND) && tx_ready;
    assign hb_in_send = (state_q == SEND) && (cur_src_q == HB_SRC);
    assign hb_done    = handshake && (cur_src_q == HB_SRC);
    assign hb_expire  = hb_en && (hb_cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        capture_hb  = 1'b0;
        capture_req = 1'b0;
        req_ready   = '0;
        case (state_q)
            IDLE: begin
                if (hb_pending_q) begin
                    capture_hb = 1'b1;
                    state_d    = SEND;
                end else if (pick_any) begin
                    capture_req = 1'b1;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Gated by rst so no requester sees an accept while the word would be dropped.
        if (capture_req && !rst) begin
            req_ready = pick_gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_q  <= '0;
            cur_src_q  <= '0;
            rr_ptr_q   <= '0;
            tx_count_q <= '0;
        end else begin
            if (capture_hb) begin
                tx_data_q <= HB_DATA;
                cur_src_q <= HB_SRC;
            end else if (capture_req) begin
                tx_data_q <= pick_data;
                cur_src_q <= pick_idx;
            end
            if (handshake) begin
                tx_count_q <= tx_count_q + 16'd1;
                if (cur_src_q != HB_SRC) begin
                    rr_ptr_q <= wrap_inc(cur_src_q, N_REQ);
                end
            end
        end
    end

    // Pending is held through the heartbeat's own SEND and only drops at its handshake,
    // so an expiry landing on that handshake re-arms it without counting as a miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            hb_cnt_q     <= HB_RELOAD;
            hb_pending_q <= 1'b0;
            hb_miss_q    <= 1'b0;
        end else if (hb_en) begin
            if (hb_expire) begin
                hb_cnt_q     <= HB_RELOAD;
                hb_pending_q <= 1'b1;
                if (hb_pending_q && !hb_done) begin
                    hb_miss_q <= 1'b1;
                end
            end else begin
                hb_cnt_q <= hb_cnt_q - 32'd1;
                if (hb_done) begin
                    hb_pending_q <= 1'b0;
                end
            end
        end else begin
            hb_cnt_q <= HB_RELOAD;
            if (hb_done || !hb_in_send) begin
                hb_pending_q <= 1'b0;
            end
        end
    end

    assign tx_valid = (state_q == SEND);
    assign tx_data  = tx_data_q;
    assign cur_src  = cur_src_q;
    assign hb_miss  = hb_miss_q;
    assign tx_count = tx_count_q;

endmodule
